// File: rtl/h_ram8.sv
// ---------------------------------------------------------------------------
// h_ram8 : eight-word x 16-bit register memory with sequenced bulk clear.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   in       in  16   write data
//   load     in   1   write request
//   address  in   3   read/write word select
//   clr      in   1   bulk-clear start request
//   out      out 16   mem[address], combinational
//   busy     out  1   clear sequence in progress (registered)
//   done     out  1   one-cycle pulse after word 7 is cleared (registered)
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | normal read/write; clr starts a clear sequence
// CLEAR  | zeroing mem[cnt] each edge; load and clr ignored
// ---------------------------------------------------------------------------
module h_ram8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [2:0]  address,
    input  logic        clr,
    output logic [15:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] mem_q [8];
    logic [15:0] mem_d [8];
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [1:0]  ld_l1;
    logic [3:0]  ld_l2;
    logic [7:0]  ld;
    logic [7:0]  ld_eff;

    // Three-level 1-to-2 demux tree: address[2], then [1], then [0].
    always_comb begin
        ld_l1 = address[2] ? {load, 1'b0} : {1'b0, load};
        ld_l2 = '0;
        ld    = '0;
        for (int j = 0; j < 2; j++) begin
            ld_l2[2*j+1] = ld_l1[j] &  address[1];
            ld_l2[2*j]   = ld_l1[j] & ~address[1];
        end
        for (int j = 0; j < 4; j++) begin
            ld[2*j+1] = ld_l2[j] &  address[0];
            ld[2*j]   = ld_l2[j] & ~address[0];
        end
    end

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clr) state_d = S_CLEAR;
            S_CLEAR: if (cnt_q == 3'd7) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 8; i++) begin
            mem_d[i] = mem_q[i];
        end
        // A clr in the same cycle as load wins; the write is dropped.
        ld_eff = (state_q == S_IDLE && !clr) ? ld : 8'h00;

        if (state_q == S_IDLE) begin
            if (clr) begin
                cnt_d = 3'd0;
            end
            for (int i = 0; i < 8; i++) begin
                if (ld_eff[i]) mem_d[i] = in;
            end
        end else begin
            mem_d[cnt_q] = 16'h0000;
            cnt_d        = cnt_q + 3'd1;   // wraps to 0 after word 7
        end

        busy_d = (state_d == S_CLEAR);
        done_d = (state_q == S_CLEAR) && (cnt_q == 3'd7);
    end

    assign out  = mem_q[address];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_h_ram8.sv
module tb_h_ram8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        load;
    logic [2:0]  address;
    logic        clr;
    logic [15:0] dout;
    logic        busy;
    logic        done;

    h_ram8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (din),
        .load    (load),
        .address (address),
        .clr     (clr),
        .out     (dout),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] out;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model: plain array plus the edge number at which the last
    // clear was accepted. Word k is zeroed at edge start+1+k.
    logic [15:0] ref_mem [8];
    int          edge_n    = 0;
    int          clr_start = -1000;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
        clr_start = -1000;
    endtask

    // One clock cycle: drive inputs, take the edge, update model, queue expectation.
    task automatic step(input logic l, input logic c, input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        load    = l;
        clr     = c;
        address = a;
        din     = d;
        @(posedge clk);
        edge_n++;
        if (rst_n) begin
            if (edge_n > clr_start && edge_n <= clr_start + 8)
                ref_mem[edge_n - clr_start - 1] = 16'h0;
            else if (c)
                clr_start = edge_n;
            else if (l)
                ref_mem[a] = d;
        end
        e.out  = ref_mem[a];
        e.busy = rst_n && (edge_n >= clr_start) && (edge_n < clr_start + 8);
        e.done = rst_n && (edge_n == clr_start + 8);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic sweep();
        for (int a = 0; a < 8; a++) step(1'b0, 1'b0, a[2:0], 16'h0);
    endtask

    task automatic fill(input logic [15:0] v);
        for (int a = 0; a < 8; a++) step(1'b1, 1'b0, a[2:0], v);
    endtask

    // Monitor: compare DUT outputs against queued expectations each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out",  dout, e.out);
            chk("busy", {15'h0, busy}, {15'h0, e.busy});
            chk("done", {15'h0, done}, {15'h0, e.done});
        end
    end

    initial begin
        load = 0; clr = 0; address = 0; din = 0;
        do_reset();
        #12;
        chk("reset_out",  dout, 16'h0);
        chk("reset_busy", {15'h0, busy}, 16'h0);
        chk("reset_done", {15'h0, done}, 16'h0);
        sweep();
        rst_n = 1'b1;

        // Write then read
        step(1'b1, 1'b0, 3'd3, 16'h1234);
        step(1'b1, 1'b0, 3'd7, 16'hBEEF);
        sweep();
        for (int a = 0; a < 8; a++) step(1'b1, 1'b0, a[2:0], 16'h1111 * (a + 1));
        sweep();

        // Normal clear, watching word 7
        fill(16'hFFFF);
        step(1'b0, 1'b1, 3'd7, 16'h0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 3'd7, 16'h0);
        sweep();

        // Clear overriding load, plus load lost mid-clear
        fill(16'h7E7E);
        step(1'b1, 1'b1, 3'd2, 16'hAAAA);
        step(1'b0, 1'b0, 3'd2, 16'h0);
        step(1'b0, 1'b0, 3'd2, 16'h0);
        step(1'b1, 1'b0, 3'd5, 16'h5555);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 3'd5, 16'h0);
        step(1'b0, 1'b0, 3'd2, 16'h0);
        step(1'b0, 1'b0, 3'd5, 16'h0);

        // Reset mid-clear
        fill(16'hFFFF);
        step(1'b0, 1'b1, 3'd7, 16'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'd7, 16'h0);
        do_reset();
        #1;
        chk("midclr_busy", {15'h0, busy}, 16'h0);
        chk("midclr_done", {15'h0, done}, 16'h0);
        chk("midclr_out",  dout, 16'h0);
        sweep();
        rst_n = 1'b1;
        step(1'b1, 1'b0, 3'd1, 16'h0042);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'd1, 16'h0);
        sweep();

        // Back-to-back clear with clr held high
        fill(16'hC3C3);
        for (int k = 0; k < 22; k++) step(1'b0, 1'b1, k[2:0], 16'h0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 3'd0, 16'h0);

        // Randomized traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0,
                 3'($urandom_range(0, 7)), 16'($urandom));
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 16'h0);
        sweep();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/h_ram8.md
# h_ram8

Eight-word × 16-bit register memory for the memory subsystem. It sits directly downstream of the 1-to-2 demux stage: a three-level tree of those demuxes fans `load` out into a one-hot per-word load vector, and each word register consumes its line. It also provides a sequenced bulk-clear operation with a busy/done handshake, so higher-level memory blocks can zero a bank without issuing eight separate writes.

## Interface
- No parameters. Word count is fixed at 8 and word width at 16.
- `clk`  in  1  single clock; all state changes occur on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in`  in  16  write data.
- `load`  in  1  write request, sampled at the rising edge.
- `address`  in  3  word select for both read and write.
- `clr`  in  1  bulk-clear start request, sampled at the rising edge.
- `out`  out  16  read data, equal to `mem[address]`. Combinational from the current address.
- `busy`  out  1  high while the clear sequence runs.
- `done`  out  1  single-cycle pulse when the clear sequence completes.

## Operation
- Storage is `mem[0..7]`, 16 bits each.
- **Reset** (asynchronous, while `rst_n`=0):
  - all `mem` words = 0
  - state = IDLE, clear counter `cnt` = 0
  - `busy` = 0, `done` = 0
  - `out` = 0
- **Load decode:** `load` is routed through a demux tree keyed by `address[2]`, then `address[1]`, then `address[0]`. This produces `ld[7:0]` with at most one bit set. The effective load is `ld` gated by (state == IDLE && !clr).
- **Write:** in IDLE with `load`=1 and `clr`=0, the rising edge sets `mem[address] <= in`. All other words hold.
- **Read:** `out` = `mem[address]` at all times. There is no read enable and no read latency.
- **FSM, two states:**
  - IDLE, `clr`=1: go to CLEAR with `cnt` <= 0. Any `load` in that same cycle is dropped.
  - IDLE, otherwise: stay in IDLE and perform the write if `load`=1.
  - CLEAR: on each edge, `mem[cnt]` <= 0 and `cnt` <= `cnt`+1 (3-bit).
  - CLEAR with `cnt`==7: clear word 7, go to IDLE, and `cnt` wraps to 0.
  - CLEAR: `load` and `clr` are both ignored. A write issued during CLEAR is lost, not queued.
- **`busy`:** registered, equal to (state == CLEAR).
- **`done`:** registered. It is 1 for exactly the one cycle after the edge that clears word 7, and 0 otherwise.
- **Reset mid-clear:** aborts the sequence immediately and returns all outputs to their reset values. No `done` pulse is produced.
- **`clr` held high across completion:** the edge that returns the FSM to IDLE does not sample `clr`. The next edge, seen from IDLE, starts a new sequence, so `done` and the new `busy` can be observed back to back.

## Timing
- **Write-to-read:** a write at edge T is visible on `out` immediately after T, provided `address` still selects that word.
- **Clear sequence:**
  - `clr` is sampled at edge T0.
  - `busy` rises after T0.
  - Word k is cleared at edge T0+1+k, for k = 0..7.
  - `busy` falls and `done` rises after T0+8. `done` falls after T0+9.
  - `busy` is therefore high for exactly 8 cycles.
- **During CLEAR:** the read path stays live. Words not yet cleared still return their old contents.
- **Clock gating:** none. Every register updates only on the `clk` rising edge or on assertion of `rst_n`.

## Test plan
- **Reset:** hold `rst_n`=0 mid-cycle → `out`=0x0000, `busy`=0, `done`=0, and every address reads 0.
- **Write then read:** write 0x1234 to addr 3 and 0xBEEF to addr 7, then sweep `address` 0..7 → reads 0,0,0,0x1234,0,0,0,0xBEEF. Repeat with all eight addresses loaded as 0x1111×(addr+1) to confirm one-hot decode.
- **Clear, normal:** fill all words with 0xFFFF, pulse `clr` at T0, keep `address`=7:
  - `busy` is high T0+1..T0+8.
  - `out` stays 0xFFFF until edge T0+8, then reads 0x0000.
  - `done` is high one cycle after T0+8.
  - All words read 0 afterwards.
- **Clear overriding load:** in IDLE assert `clr` and `load` (addr 2, 0xAAAA) together → no write happens and word 2 ends at 0. Assert `load` (addr 5, 0x5555) at T0+3 → word 5 stays 0 after completion.
- **Reset mid-clear:** fill with 0xFFFF, start clear, deassert `rst_n` at T0+4 → `busy`=0 at once, no `done` pulse, all words 0. After release, a write of 0x0042 to addr 1 succeeds.
- **Back-to-back clear:** hold `clr`=1 continuously → `done` pulses after T0+8, the next sequence starts at T0+9, and `busy` is high again after T0+9.
